// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
//   Shared definitions for the 4-bit processor core: sequencer state
//   encoding, instruction field positions, opcode constants and a helper
//   that recognises the HALT instruction word.
// ---------------------------------------------------------------------------
package proc_pkg;

  // Sequencer states, in the order an instruction walks through them
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Instruction word layout: [11:8] opcode, [7:6] rd, [5:4] rs, [3:0] imm
  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int RS_MSB  = 5;
  localparam int RS_LSB  = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  // Opcode 0000 is NOP, except the one exact word 0x00F which is HALT
  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] HALT_IMM = 4'hF;

  // HALT needs every field to match, so NOPs with other rd/rs/imm still retire
  function automatic logic is_halt(input logic [11:0] word);
    return (word[OPC_MSB:OPC_LSB] == OP_NOP) &&
           (word[RD_MSB:RD_LSB]   == 2'b00)  &&
           (word[RS_MSB:RS_LSB]   == 2'b00)  &&
           (word[IMM_MSB:IMM_LSB] == HALT_IMM);
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle FETCH-DECODE-EXEC-WB sequencer for the 4-bit core. Fetches
//   instruction words over a req/ack handshake, presents the opcode to the
//   external control decoder, registers the decoder's controls and drives the
//   register-file addresses, immediate and one-cycle write strobe. Owns the PC
//   and a saturating count of retired instructions.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   run                      1 = keep executing, 0 = stop after current instr
//   imem_req/imem_addr       fetch request and address (address = pc)
//   imem_ack/imem_rdata      fetch completion and instruction word
//   opcode_o                 latched opcode to the control decoder
//   dec_reg_write/alu_src/alu_op  decoder outputs (combinational from opcode_o)
//   alu_op_o/alu_src_o/imm_o ALU controls and immediate
//   rf_raddr_a/b, rf_waddr   register-file addresses (rd, rs, rd)
//   rf_we                    register-file write strobe, high for WB only
//   pc_o                     current program counter
//   busy/halted              status: busy outside IDLE/HALT, halted in HALT
//   retired_cnt              instructions completed, saturating
// ---------------------------------------------------------------------------
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 12,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [3:0]         opcode_o,
  input  logic               dec_reg_write,
  input  logic               dec_alu_src,
  input  logic [3:0]         dec_alu_op,
  output logic [3:0]         alu_op_o,
  output logic               alu_src_o,
  output logic [3:0]         imm_o,
  output logic [1:0]         rf_raddr_a,
  output logic [1:0]         rf_raddr_b,
  output logic [1:0]         rf_waddr,
  output logic               rf_we,
  output logic [PC_W-1:0]    pc_o,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_cnt
);

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr_q;
  logic               reg_write_q;

  // The instruction register only loads in FETCH, so every field derived from
  // it is steady from DECODE through WB, including the cycle rf_we is high.
  assign opcode_o   = instr_q[OPC_MSB:OPC_LSB];
  assign imm_o      = instr_q[IMM_MSB:IMM_LSB];
  assign rf_raddr_a = instr_q[RD_MSB:RD_LSB];
  assign rf_raddr_b = instr_q[RS_MSB:RS_LSB];
  assign rf_waddr   = instr_q[RD_MSB:RD_LSB];
  assign imem_addr  = pc;
  assign pc_o       = pc;

  // Single FSM process: every status and strobe output is set on the edge
  // that enters the state it belongs to, so they are all plain flops.
  // imem_req is a flop cleared by the async reset, which is what makes it
  // drop immediately when reset hits in the middle of a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr_q     <= '0;
      alu_op_o    <= '0;
      alu_src_o   <= 1'b0;
      reg_write_q <= 1'b0;
      retired_cnt <= '0;
      imem_req    <= 1'b0;
      rf_we       <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end

        // Ack is only looked at here, so a stray ack with no request is ignored
        FETCH: begin
          if (imem_ack) begin
            instr_q  <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end

        DECODE: begin
          alu_op_o    <= dec_alu_op;
          alu_src_o   <= dec_alu_src;
          reg_write_q <= dec_reg_write;
          if (is_halt(instr_q[11:0])) begin
            state  <= HALT;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state <= EXEC;
          end
        end

        EXEC: begin
          state <= WB;
          rf_we <= reg_write_q;
        end

        WB: begin
          rf_we <= 1'b0;
          pc    <= pc + PC_W'(1);
          if (retired_cnt != {CNT_W{1'b1}}) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
          end
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        // PC is left pointing at the HALT word, so the next run refetches it
        HALT: begin
          if (!run) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          rf_we    <= 1'b0;
          busy     <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule
